route_scheduler: RTL

ROUTE_SCHEDULER -- requirements
Module: route_scheduler

---
 rtl/util_pack.sv | 16 +
 rtl/FifoBuffer.sv | 25 ++
 rtl/route_scheduler.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/util_pack.sv
// Shared types for the route scheduler: select-word layout and sequencer states.
package util_pack;

  localparam int unsigned DEF_MODULE_SLOTS = 32;
  localparam int unsigned DEF_NTT_SLOTS    = 32;
  localparam int unsigned DEF_SW           = $clog2(DEF_NTT_SLOTS);

  typedef logic [DEF_MODULE_SLOTS-1:0][DEF_SW-1:0] slot_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

endpackage

// File: rtl/FifoBuffer.sv
// Fixed-latency shift delay: dout is din delayed by exactly CYCLES clocks.
module FifoBuffer #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned CYCLES    = 5
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout
);

  logic [DATA_SIZE-1:0] pipe [CYCLES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < CYCLES; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < CYCLES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[CYCLES-1];

endmodule

// File: rtl/route_scheduler.sv
// Sequences route-table entries onto the interconnect selects and tracks each
// issued step through the fixed interconnect latency.
module route_scheduler
  import util_pack::*;
#(
  parameter int unsigned MODULE_SLOTS = 32,
  parameter int unsigned NTT_SLOTS    = 32,
  parameter int unsigned STAGE_MODULE = 5,
  parameter int unsigned DEPTH        = 16,
  localparam int unsigned SW = $clog2(NTT_SLOTS),
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             cfg_wren,
  input  logic [AW-1:0]                    cfg_addr,
  input  logic [MODULE_SLOTS-1:0][SW-1:0]  cfg_module_slots,
  input  logic [MODULE_SLOTS-1:0][SW-1:0]  cfg_ram_slots,
  output logic                             cfg_err,
  input  logic                             start,
  input  logic [AW:0]                      num_steps,
  input  logic                             issue_ready,
  output logic                             busy,
  output logic [MODULE_SLOTS-1:0][SW-1:0]  module_slots,
  output logic [MODULE_SLOTS-1:0][SW-1:0]  ram_slots,
  output logic                             slot_valid,
  output logic                             result_valid,
  output logic [AW-1:0]                    result_step,
  output logic                             done
);

  localparam int unsigned OW = $clog2(STAGE_MODULE + 2) + 1;

  typedef logic [MODULE_SLOTS-1:0][SW-1:0] sel_t;

  sel_t mod_tab [DEPTH];
  sel_t ram_tab [DEPTH];

  sched_state_t  state, state_d;
  logic [AW-1:0] step, step_d, slot_step, slot_step_d;
  logic [AW:0]   count, count_d, req_steps;
  logic [OW-1:0] outstanding, outstanding_d;
  sel_t          module_slots_d, ram_slots_d;
  logic          slot_valid_d, done_d, issue_fire;
  logic [AW:0]   line_out;

  // Table is deliberately not reset so contents survive rstn.
  always_ff @(posedge clk) begin
    if (cfg_wren && !busy) begin
      mod_tab[cfg_addr] <= cfg_module_slots;
      ram_tab[cfg_addr] <= cfg_ram_slots;
    end
  end

  assign req_steps = (num_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_steps;

  always_comb begin
    state_d        = state;
    step_d         = step;
    count_d        = count;
    slot_step_d    = slot_step;
    module_slots_d = module_slots;
    ram_slots_d    = ram_slots;
    slot_valid_d   = 1'b0;
    done_d         = 1'b0;
    issue_fire     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (req_steps == '0) begin
            done_d = 1'b1;
          end else begin
            count_d = req_steps;
            step_d  = '0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (issue_ready) begin
          issue_fire     = 1'b1;
          module_slots_d = mod_tab[step];
          ram_slots_d    = ram_tab[step];
          slot_valid_d   = 1'b1;
          slot_step_d    = step;
          step_d         = AW'(step + AW'(1));
          if ({1'b0, step} == count - (AW+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // In-flight count: issued steps whose result has not yet emerged.
    outstanding_d = outstanding + OW'(issue_fire) - OW'(result_valid);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      step         <= '0;
      count        <= '0;
      slot_step    <= '0;
      outstanding  <= '0;
      module_slots <= '0;
      ram_slots    <= '0;
      slot_valid   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state        <= state_d;
      step         <= step_d;
      count        <= count_d;
      slot_step    <= slot_step_d;
      outstanding  <= outstanding_d;
      module_slots <= module_slots_d;
      ram_slots    <= ram_slots_d;
      slot_valid   <= slot_valid_d;
      busy         <= (state_d != IDLE);
      done         <= done_d;
      cfg_err      <= cfg_wren && busy;
    end
  end

  FifoBuffer #(
    .DATA_SIZE (1 + AW),
    .CYCLES    (STAGE_MODULE)
  ) u_delay (
    .clk  (clk),
    .rstn (rstn),
    .din  ({slot_valid, slot_step}),
    .dout (line_out)
  );

  assign result_valid = line_out[AW];
  assign result_step  = line_out[AW-1:0];

endmodule
